mem_port_arbiter: RTL
=====================

# mem_port_arbiter

- Shares the single-ported data memory between the single-cycle core's load/store path and an external host port (loader/debug DMA).
- Inserts core stalls through the PC's `PCWrite` input and a register-write hold when the host wins a conflicting cycle.
- Bounds host starvation with a wait counter and core starvation with a host burst limit.

## Interface
- `ADDR_W`, 32: address width of memory, core and host ports.
- `DATA_W`, 32: data width.
- `WAIT_LIMIT`, 4: conflicting cycles the host is denied before it gains priority; legal range ≥1.
- `MAX_BURST`, 4: maximum host grants per priority window; legal range ≥1.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `core_req` in 1: core accesses memory this cycle (load or `MemWrite`).
- `core_we` in 1: core store.
- `core_addr` in ADDR_W: core address (`ALUResult`).
- `core_wdata` in DATA_W: core store data (`WriteData`).
- `core_rdata` out DATA_W: core load data (`ReadData`).
- `pc_write` out 1: drives PC `PCWrite`; 0 means the core holds its PC.
- `core_hold` out 1: core lost arbitration; the datapath gates `RegWrite` with `!core_hold`.
- `host_valid` in 1: host request.
- `host_ready` out 1: host request accepted this cycle.
- `host_we` in 1: host write.
- `host_addr` in ADDR_W: host address.
- `host_wdata` in DATA_W: host write data.
- `host_rvalid` out 1: host read data valid.
- `host_rdata` out DATA_W: host read data.
- `mem_we` out 1: memory write enable; write is synchronous.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data, combinational read.

## Operation
- **States:** the FSM has two states, `CORE_PRI` and `HOST_PRI`.
- **Counters:** `wait_cnt` is `$clog2(WAIT_LIMIT+1)` bits; `burst_cnt` is `$clog2(MAX_BURST+1)` bits. Both are unsigned and saturate at their limits.
- **`host_grant` (combinational):**
  - Is 0 when `host_valid`=0.
  - In `CORE_PRI`, equals `!core_req`.
  - In `HOST_PRI`, is 1.
- **Memory mux:** when `host_grant`=1, `mem_*` carries the host signals. Otherwise `mem_*` carries the core signals, with `mem_we = core_req & core_we`.
- **Core-side outputs:**
  - `core_hold = core_req & host_grant`.
  - `pc_write = !core_hold`.
  - `core_rdata = mem_rdata` (pass-through).
- **Host-side outputs:**
  - `host_ready = host_grant`.
  - A read is accepted when `host_grant & !host_we`.
- **`CORE_PRI` transitions:**
  - A cycle with `host_valid & core_req` (host denied) increments `wait_cnt`.
  - Any host grant, or `host_valid`=0, clears `wait_cnt`.
  - On a denial while `wait_cnt == WAIT_LIMIT-1`, go to `HOST_PRI` next cycle and clear `wait_cnt`.
- **`HOST_PRI` transitions:**
  - Each grant increments `burst_cnt`.
  - Return to `CORE_PRI` and clear `burst_cnt` when the grant makes `burst_cnt` reach `MAX_BURST`, or when `host_valid`=0.
- **Stalled core instruction:** a held core access is replayed unchanged next cycle, because the PC did not advance. The arbiter keeps no core-side state.
- **Write/read ordering:** a host write followed by a core read of the same address returns the new data, since the memory write is synchronous.

## Timing
- **Reset values (`reset`=0):**
  - State is `CORE_PRI`; `wait_cnt` and `burst_cnt` are 0.
  - `host_rvalid` is 0 and `host_rdata` is 0.
  - `host_ready`=0, `core_hold`=0, `pc_write`=1, `mem_we`=0, all forced while reset is asserted.
- **Zero-latency paths:** arbitration and the core path are fully combinational within the cycle.
- **Host read latency:** `host_rvalid`=1 exactly one cycle after an accepted read, with `host_rdata` registered from `mem_rdata`. It is 0 otherwise, including after writes.
- **Host handshake:** the host must hold `host_*` stable until `host_ready`=1. A transfer completes on `host_valid & host_ready` at the clock edge.
- **Reset mid-operation:** a pending `host_rvalid` is dropped and no response is produced. An in-progress `HOST_PRI` window is abandoned.
- **Worst-case stalls:**
  - The core is stalled at most `MAX_BURST` consecutive cycles.
  - The host waits at most `WAIT_LIMIT` denied cycles before a guaranteed grant.
- **Simultaneous events:** when the transition to `HOST_PRI` coincides with `host_valid` dropping, the state still enters `HOST_PRI`. It exits on the first cycle that sees `host_valid`=0, with no grant issued.

## Structure
- Shared package/include `mem_arb_pkg` holds:
  - State encodings `CORE_PRI`=1'b0, `HOST_PRI`=1'b1.
  - Default `WAIT_LIMIT` and `MAX_BURST` constants.
- Single module, no sub-modules. The counters and FSM are small enough to inline.
- The top-level core wrapper instantiates it between the datapath, the PC `PCWrite` pin and the data memory.

## Test plan
- **Reset:** assert reset with host and core active -> `pc_write`=1, `host_ready`=0, `mem_we`=0, `host_rvalid`=0.
- **No conflict:** host write `addr=0x10`, `data=0xDEADBEEF` with `core_req`=0 -> `host_ready`=1 same cycle. A subsequent host read of `0x10` -> `host_rvalid`=1 next cycle, `host_rdata`=0xDEADBEEF.
- **Host starvation bound:** `core_req`=1 and `host_valid`=1 continuously, `WAIT_LIMIT`=4 -> 4 denied cycles, `host_ready`=1 in the 5th cycle with `core_hold`=1 and `pc_write`=0.
- **Core starvation bound:** in `HOST_PRI` with `MAX_BURST`=4 and both requesting -> 4 host grants, then the core wins the next cycle (`core_hold`=0).
- **Early exit:** `host_valid` drops after 2 grants in `HOST_PRI` -> state returns to `CORE_PRI`, `burst_cnt`=0, and the next conflict restarts the wait count.
- **Reset mid-read:** reset asserted in the cycle after an accepted host read -> `host_rvalid` never rises.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encodings and default limits for the data memory port arbiter
package mem_arb_pkg;

    // Arbitration priority state: core wins conflicts in CORE_PRI, host wins in HOST_PRI.
    typedef enum logic {
        CORE_PRI = 1'b0,
        HOST_PRI = 1'b1
    } arb_state_t;

    // Denied conflicting cycles before the host is promoted to priority.
    localparam int DEFAULT_WAIT_LIMIT = 4;
    // Host grants allowed in one priority window before the core gets the port back.
    localparam int DEFAULT_MAX_BURST  = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the single-ported data memory between the core load/store path and a host port
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   core_req/we/addr/wdata     core load/store request (ALUResult, WriteData, MemWrite)
//   core_rdata                 core load data, combinational pass-through of mem_rdata
//   pc_write                   PC PCWrite enable; 0 holds the PC so the stalled access replays
//   core_hold                  core lost arbitration this cycle; datapath gates RegWrite with it
//   host_valid/we/addr/wdata   host request, held stable until host_ready
//   host_ready                 host request accepted this cycle
//   host_rvalid/rdata          host read response, one cycle after an accepted read
//   mem_we/addr/wdata/rdata    data memory port (synchronous write, combinational read)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WAIT_LIMIT = DEFAULT_WAIT_LIMIT,
    parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              pc_write,
    output logic              core_hold,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WAIT_W  = $clog2(WAIT_LIMIT + 1);
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    arb_state_t         state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [BURST_W-1:0] burst_cnt;
    logic [BURST_W-1:0] burst_next;
    logic               host_grant;
    logic               host_denied;
    logic               read_accept;

    // Gating with reset forces the core-side and memory outputs to their idle
    // values while reset is held, even though the request inputs may be active.
    always_comb begin
        host_grant = 1'b0;
        if (reset && host_valid) begin
            host_grant = (state == HOST_PRI) ? 1'b1 : !core_req;
        end
    end

    assign host_denied = host_valid & core_req & !host_grant;
    assign read_accept = host_grant & !host_we;
    assign burst_next  = burst_cnt + 1'b1;

    always_comb begin
        if (host_grant) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else begin
            mem_we    = reset & core_req & core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end
    end

    assign core_hold  = core_req & host_grant;
    assign pc_write   = !core_hold;
    assign core_rdata = mem_rdata;
    assign host_ready = host_grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= CORE_PRI;
            wait_cnt    <= '0;
            burst_cnt   <= '0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            host_rvalid <= read_accept;
            if (read_accept) begin
                host_rdata <= mem_rdata;
            end

            case (state)
                CORE_PRI: begin
                    burst_cnt <= '0;
                    if (host_denied) begin
                        if (wait_cnt == WAIT_W'(WAIT_LIMIT - 1)) begin
                            state    <= HOST_PRI;
                            wait_cnt <= '0;
                        end else if (wait_cnt != WAIT_W'(WAIT_LIMIT)) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                HOST_PRI: begin
                    wait_cnt <= '0;
                    // A window that entered just as the host dropped its request
                    // exits here on the first idle cycle without issuing a grant.
                    if (!host_valid || burst_next == BURST_W'(MAX_BURST)) begin
                        state     <= CORE_PRI;
                        burst_cnt <= '0;
                    end else begin
                        burst_cnt <= burst_next;
                    end
                end
                default: begin
                    state <= CORE_PRI;
                end
            endcase
        end
    end

endmodule
